// File: rtl/ascii_pkg.sv
// Shared constants, types and the ordered-dither glyph table for the ASCII cell renderer.
// Glyph density rises with level: 0 is blank, 15 is solid.
package ascii_pkg;

    localparam int unsigned CELL_PX     = 16;
    localparam int unsigned DEF_H_CELLS = 40;
    localparam int unsigned DEF_V_CELLS = 30;
    localparam int unsigned NUM_CELLS   = DEF_H_CELLS * DEF_V_CELLS;
    localparam int unsigned LEVEL_W     = 4;
    localparam int unsigned OFF_W       = 4;
    localparam int unsigned GLYPH_BITS  = 16 * CELL_PX * CELL_PX;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } wr_state_e;

    // 4x4 Bayer ranks, nibble index = row*4 + col
    localparam logic [63:0] DITHER_RANK = 64'h5D7F_91B3_6E4C_A280;

    // Bit address = {level, row offset, column offset}
    function automatic logic [GLYPH_BITS-1:0] build_glyphs();
        logic [GLYPH_BITS-1:0] t;
        logic [3:0]            rank;
        t = '0;
        for (int unsigned l = 0; l < 16; l++) begin
            for (int unsigned r = 0; r < CELL_PX; r++) begin
                for (int unsigned c = 0; c < CELL_PX; c++) begin
                    rank = DITHER_RANK[((r % 4) * 4 + (c % 4)) * 4 +: 4];
                    t[l * 256 + r * 16 + c] = (l == 15) || (32'(rank) < l);
                end
            end
        end
        return t;
    endfunction

    localparam logic [GLYPH_BITS-1:0] GLYPH_TABLE = build_glyphs();

endpackage

// File: rtl/ascii_glyph_rom.sv
// Final read stage: looks up one glyph pixel and masks it with the active flag.
module ascii_glyph_rom
    import ascii_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  level_t           i_level,
    input  logic [OFF_W-1:0] i_row_off,
    input  logic [OFF_W-1:0] i_col_off,
    input  logic             i_active,
    output logic             o_pix
);

    logic [11:0] w_addr;
    logic        r_pix;

    assign w_addr = {i_level, i_row_off, i_col_off};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix <= 1'b0;
        end else begin
            r_pix <= GLYPH_TABLE[w_addr] & i_active;
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/ascii_cell_render.sv
// Character-cell renderer: stores a frame of 4-bit cell levels and draws them as glyphs.
// Define ASCII_DBUF_EN for a double-buffered cell store swapped at the end of the active raster.
module ascii_cell_render
    import ascii_pkg::*;
#(
    parameter int unsigned H_CELLS = DEF_H_CELLS,
    parameter int unsigned V_CELLS = DEF_V_CELLS
) (
    input  logic         vga_clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [3:0]   wr_level,
    input  logic         wr_sof,
    input  logic         video_on,
    input  logic [11:0]  pixel_row,
    input  logic [11:0]  pixel_column,
    output logic         ascii_pix,
    output logic         frame_done
);

    localparam int unsigned CELLS   = H_CELLS * V_CELLS;
    localparam int unsigned IDX_W   = ($clog2(CELLS) > 11) ? $clog2(CELLS) : 11;
    localparam int unsigned ROW_LIM = CELL_PX * V_CELLS;
    localparam int unsigned COL_LIM = CELL_PX * H_CELLS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    wr_state_e        r_state;
    logic             r_wr_ready;
    logic             r_frame_done;
    logic [IDX_W-1:0] r_wr_ptr;

    logic             w_accept;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_last;
    logic             w_swap;
    logic             w_active;
    logic [IDX_W-1:0] w_rd_idx;

    logic             r_s1_active;
    logic [IDX_W-1:0] r_s1_idx;
    logic [OFF_W-1:0] r_s1_row_off;
    logic [OFF_W-1:0] r_s1_col_off;
    logic             r_s2_active;
    level_t           r_s2_level;
    logic [OFF_W-1:0] r_s2_row_off;
    logic [OFF_W-1:0] r_s2_col_off;

    // A start-of-frame write always lands at cell 0
    assign w_accept = wr_valid && r_wr_ready && !reset;
    assign w_wr_idx = wr_sof ? '0 : r_wr_ptr;
    assign w_last   = (w_wr_idx == LAST_IDX);
    assign w_swap   = (r_state == ST_FULL) && (32'(pixel_row) == ROW_LIM)
                      && (pixel_column == 12'd0);

    assign w_active = video_on && (32'(pixel_row) < ROW_LIM)
                      && (32'(pixel_column) < COL_LIM);
    assign w_rd_idx = w_active
                      ? IDX_W'(32'(pixel_row[11:4]) * H_CELLS + 32'(pixel_column[11:4]))
                      : '0;

    // Write-side FSM, pointer and frame_done pulse
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_wr_ready   <= 1'b0;
            r_wr_ptr     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_wr_ptr <= w_last ? '0 : w_wr_idx + IDX_W'(1);
            end
            case (r_state)
                ST_FILL: begin
                    r_wr_ready <= 1'b1;
`ifdef ASCII_DBUF_EN
                    if (w_accept && w_last) begin
                        r_state    <= ST_FULL;
                        r_wr_ready <= 1'b0;
                    end
`endif
                end
                ST_FULL: begin
                    r_wr_ready <= 1'b0;
                    if (w_swap) begin
                        r_state    <= ST_FILL;
                        r_wr_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_FILL;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ASCII_DBUF_EN
    level_t r_mem [2][CELLS];
    logic   r_sel;

    // r_sel names the front (displayed) bank; writes go to the other one
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_sel <= 1'b0;
        end else if (w_swap) begin
            r_sel <= ~r_sel;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (w_accept) begin
            r_mem[~r_sel][w_wr_idx] <= wr_level;
        end
    end

    always_ff @(posedge vga_clk) begin
        r_s2_level <= r_mem[r_sel][r_s1_idx];
    end
`else
    level_t r_mem [CELLS];

    // Read-before-write: a same-cycle read of the written cell sees the old level
    always_ff @(posedge vga_clk) begin
        if (w_accept) begin
            r_mem[w_wr_idx] <= wr_level;
        end
    end

    always_ff @(posedge vga_clk) begin
        r_s2_level <= r_mem[r_s1_idx];
    end
`endif

    // Read pipeline active flags
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_s1_active <= 1'b0;
            r_s2_active <= 1'b0;
        end else begin
            r_s1_active <= w_active;
            r_s2_active <= r_s1_active;
        end
    end

    always_ff @(posedge vga_clk) begin
        r_s1_idx     <= w_rd_idx;
        r_s1_row_off <= pixel_row[3:0];
        r_s1_col_off <= pixel_column[3:0];
        r_s2_row_off <= r_s1_row_off;
        r_s2_col_off <= r_s1_col_off;
    end

    ascii_glyph_rom u_glyph_rom (
        .clk       (vga_clk),
        .reset     (reset),
        .i_level   (r_s2_level),
        .i_row_off (r_s2_row_off),
        .i_col_off (r_s2_col_off),
        .i_active  (r_s2_active),
        .o_pix     (ascii_pix)
    );

    assign wr_ready   = r_wr_ready;
    assign frame_done = r_frame_done;

endmodule
